// File: rtl/pipeline_event_counter.sv
// Run-window event monitor for the 5-stage CPU: counts cycles, stalls, flushes and
// retired instructions while running, saturating each counter and freezing in DONE.
module pipeline_event_counter #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic             clear_i,
  input  logic [1:0]       sel_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cycles_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic [1:0]       state_o
);
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W:0]   MAXC = (CNT_W+1)'(MAX_CYCLES);

  state_t                  r_state, w_state_nx;
  logic [3:0][CNT_W-1:0]   r_cnt;
  logic                    r_ovf;
  logic [3:0]              w_ev, w_inc, w_sat;
  logic                    w_count, w_hit_max;

  // Counter index: 0 cycles, 1 stalls, 2 flushes, 3 retired (matches sel_i)
  assign w_count = (r_state == S_RUN) && start_i;
  assign w_ev    = {retire_i, flush_i, stall_i & ~branch_i, 1'b1};

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    assign w_inc[g] = w_count && w_ev[g] && (r_cnt[g] != CMAX);
    assign w_sat[g] = w_count && w_ev[g] && (r_cnt[g] == CMAX);
  end

  // The window closes on the edge that actually lands cycles on MAX_CYCLES
  assign w_hit_max = (MAX_CYCLES != 0) && w_inc[0] &&
                     (({1'b0, r_cnt[0]} + (CNT_W+1)'(1)) == MAXC);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nx = S_RUN;
      S_RUN:   if (w_hit_max) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_DONE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i || clear_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      for (int i = 0; i < 4; i++)
        if (w_inc[i]) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      if (|w_sat) r_ovf <= 1'b1;
    end
  end

  assign cycles_o     = r_cnt[0];
  assign stall_cnt_o  = r_cnt[1];
  assign flush_cnt_o  = r_cnt[2];
  assign retire_cnt_o = r_cnt[3];
  assign cnt_o        = r_cnt[sel_i];
  assign done_o       = (r_state == S_DONE);
  assign ovf_o        = r_ovf;
  assign state_o      = r_state;
endmodule

// File: tb/tb_pipeline_event_counter.sv
// Self-checking bench: two configurations (32-bit/64-cycle window and 4-bit/unbounded)
// driven in lockstep and compared against a per-edge behavioural model.
module tb_pipeline_event_counter;
  logic clk = 1'b0;
  logic rst = 1'b0, clr = 1'b0, start = 1'b0;
  logic stall = 1'b0, branch = 1'b0, flush = 1'b0, retire = 1'b0;
  logic [1:0] sel = 2'd0;

  logic [31:0] a_cnt, a_cyc, a_stl, a_fl, a_ret;
  logic        a_done, a_ovf;
  logic [1:0]  a_st;
  logic [3:0]  b_cnt, b_cyc, b_stl, b_fl, b_ret;
  logic        b_done, b_ovf;
  logic [1:0]  b_st;

  int n_chk = 0, n_fail = 0;

  // Model state, index 0 = wide instance, 1 = 4-bit instance
  int     m_st  [2];
  longint m_c   [2][4];
  bit     m_ovf [2];

  always #5 clk = ~clk;

  pipeline_event_counter #(.CNT_W(32), .MAX_CYCLES(64)) u_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
    .flush_i(flush), .retire_i(retire), .clear_i(clr), .sel_i(sel),
    .cnt_o(a_cnt), .cycles_o(a_cyc), .stall_cnt_o(a_stl), .flush_cnt_o(a_fl),
    .retire_cnt_o(a_ret), .done_o(a_done), .ovf_o(a_ovf), .state_o(a_st));

  pipeline_event_counter #(.CNT_W(4), .MAX_CYCLES(0)) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
    .flush_i(flush), .retire_i(retire), .clear_i(clr), .sel_i(sel),
    .cnt_o(b_cnt), .cycles_o(b_cyc), .stall_cnt_o(b_stl), .flush_cnt_o(b_fl),
    .retire_cnt_o(b_ret), .done_o(b_done), .ovf_o(b_ovf), .state_o(b_st));

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One edge of the reference: window of mx counted cycles (0 = endless), w-bit saturation
  task automatic step(input int k, input int w, input int mx);
    longint lim;
    logic [3:0] ev;
    bit cyc_inc;
    lim = (longint'(1) << w) - 1;
    ev  = {retire, flush, stall & ~branch, 1'b1};
    if (!rst || clr) begin
      m_st[k] = 0; m_ovf[k] = 0;
      for (int i = 0; i < 4; i++) m_c[k][i] = 0;
    end else if (m_st[k] == 0) begin
      if (start) m_st[k] = 1;
    end else if (m_st[k] == 1) begin
      if (start) begin
        cyc_inc = 0;
        for (int i = 0; i < 4; i++)
          if (ev[i]) begin
            if (m_c[k][i] >= lim) m_ovf[k] = 1;
            else begin
              m_c[k][i]++;
              if (i == 0) cyc_inc = 1;
            end
          end
        if (mx != 0 && cyc_inc && m_c[k][0] == mx) m_st[k] = 2;
      end
    end else if (m_st[k] != 2) begin
      m_st[k] = 0;
    end
  endtask

  task automatic compare();
    chk("a_cycles", a_cyc, m_c[0][0]);
    chk("a_stalls", a_stl, m_c[0][1]);
    chk("a_flushes", a_fl, m_c[0][2]);
    chk("a_retired", a_ret, m_c[0][3]);
    chk("a_cnt_sel", a_cnt, m_c[0][sel]);
    chk("a_state", a_st, m_st[0]);
    chk("a_done", a_done, longint'(m_st[0] == 2));
    chk("a_ovf", a_ovf, m_ovf[0]);
    chk("b_cycles", b_cyc, m_c[1][0]);
    chk("b_retired", b_ret, m_c[1][3]);
    chk("b_stalls", b_stl, m_c[1][1]);
    chk("b_flushes", b_fl, m_c[1][2]);
    chk("b_cnt_sel", b_cnt, m_c[1][sel]);
    chk("b_state", b_st, m_st[1]);
    chk("b_ovf", b_ovf, m_ovf[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    step(0, 32, 64);
    step(1, 4, 0);
    #1;
    compare();
  endtask

  task automatic ev_in(input logic [3:0] v);
    {stall, branch, flush, retire} = v;
  endtask

  task automatic do_clear();
    clr = 1'b1; start = 1'b0; ev_in(4'b0); tick(); clr = 1'b0;
  endtask

  logic [3:0] mix [10] = '{4'b1001, 4'b1011, 4'b1000, 4'b1101, 4'b1100,
                           4'b0011, 4'b0001, 4'b0001, 4'b0000, 4'b0000};

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_ovf[i] = 0;
      for (int j = 0; j < 4; j++) m_c[i][j] = 0;
    end

    // Reset held two edges with inputs toggling
    for (int i = 0; i < 2; i++) begin
      rst = 1'b0; start = 1'($urandom); clr = 1'($urandom);
      ev_in(4'($urandom)); tick();
    end
    chk("rst_cycles", a_cyc, 0);
    chk("rst_state", a_st, 0);
    chk("rst_done", a_done, 0);
    chk("rst_ovf", a_ovf, 0);

    rst = 1'b1; clr = 1'b0; ev_in(4'b0); start = 1'b1; tick();
    chk("start_state", a_st, 1);
    chk("start_cycles", a_cyc, 0);

    // Plain run: window of 64 then frozen
    for (int i = 0; i < 70; i++) begin
      tick();
      if (i == 62) chk("pre_done", a_done, 0);
      if (i == 63) chk("done_at_64", a_done, 1);
    end
    chk("plain_cycles", a_cyc, 64);
    chk("plain_state", a_st, 2);

    // Event mix
    do_clear(); start = 1'b1; tick();
    for (int i = 0; i < 10; i++) begin ev_in(mix[i]); tick(); end
    ev_in(4'b0); start = 1'b0;
    chk("mix_cycles", a_cyc, 10);
    chk("mix_stalls", a_stl, 3);
    chk("mix_flushes", a_fl, 2);
    chk("mix_retired", a_ret, 6);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s); #1;
      chk("mix_sel", a_cnt, (s == 0) ? 10 : (s == 1) ? 3 : (s == 2) ? 2 : 6);
    end
    sel = 2'd0;

    // Pause with stalls asserted throughout
    do_clear(); start = 1'b1; tick();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pause_state", a_st, 1);
    start = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("pause_cycles", a_cyc, 8);
    chk("pause_stalls", a_stl, 8);
    stall = 1'b0;

    // Saturation on the 4-bit unbounded instance
    do_clear(); start = 1'b1; tick();
    retire = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) chk("sat_ovf_pre", b_ovf, 0);
      if (i == 15) chk("sat_ovf_16", b_ovf, 1);
    end
    chk("sat_retired", b_ret, 15);
    chk("sat_cycles", b_cyc, 15);
    chk("sat_ovf", b_ovf, 1);
    chk("sat_state", b_st, 1);
    retire = 1'b0;

    // Mid-run clear, then reset and clear together
    for (int rep = 0; rep < 2; rep++) begin
      do_clear(); start = 1'b1; tick();
      for (int i = 0; i < 30; i++) begin ev_in(4'($urandom) & 4'b1011); tick(); end
      chk("mid_cycles", a_cyc, 30);
      clr = 1'b1;
      if (rep == 1) rst = 1'b0;
      tick();
      clr = 1'b0; rst = 1'b1; ev_in(4'b0);
      chk("mid_clr_cycles", a_cyc, 0);
      chk("mid_clr_retired", a_ret, 0);
      chk("mid_clr_state", a_st, 0);
      chk("mid_clr_ovf", b_ovf, 0);
    end

    // Randomized traffic with occasional clear/reset
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 9) != 0);
      ev_in(4'($urandom));
      sel = 2'($urandom);
      clr = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 89) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
